demux1to4_stream: RTL
=====================

Name: demux1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the counterpart of the 4-to-1 mux.
- Routes one valid/ready input stream to one of four output streams, chosen by a per-beat select.
- Each output has its own one-entry holding register, so a stalled output does not block traffic to the other three.
- Sits between a single producer and four independent consumers in the section-2 datapath exercises.

Parameters:
- WIDTH, 8, payload width in bits.
- NOUT, 4, number of outputs; fixed at 4, sized by SEL_W from the package.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- in_data  in  WIDTH  input payload.
- in_sel  in  2  destination output index, 0..3.
- out_valid  out  4  bit i: output i holds a beat.
- out_ready  in  4  bit i: consumer i accepts a beat.
- out_data  out  4*WIDTH  output i payload in bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset, asynchronous on rst_n=0: out_valid=4'b0000, out_data=0, all slots EMPTY. A beat in flight is discarded; no partial beat survives reset.
- Each slot is a 2-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without a load.
  - FULL -> FULL on drain and load in the same cycle.
  - EMPTY with no load stays EMPTY.
- load(i) = in_valid & in_ready & (in_sel==i).
- drain(i) = out_valid[i] & out_ready[i].
- in_ready = !out_valid[in_sel] | out_ready[in_sel]. It is combinational and depends on in_sel, so the selected slot accepts while draining (full throughput per output).
- No combinational path from in_valid to in_ready. in_ready does not depend on in_valid.
- Latency is exactly 1 cycle: a beat accepted at edge N is visible on out_valid/out_data of its slot after edge N.
- Throughput is 1 beat/cycle when consumers keep out_ready=1.
- Producer rule: while in_valid=1 and in_ready=0, in_data and in_sel are held stable. A change is a protocol violation; it is flagged by an assertion in simulation only.
- Consumer rule: out_valid[i] never drops until drain(i); out_data slice i stays stable while FULL and not drained.
- Slots are independent:
  - Back-pressure on output i stalls only beats with in_sel==i.
  - Simultaneous drain on several outputs is legal.
- out_data slice i retains its last value when EMPTY; consumers ignore it.
- Ordering is preserved per output. There is no ordering guarantee across outputs.

Optional Feature:
- Macro: DEMUX1TO4_STREAM_CNT_EN.
- With the macro defined:
  - Extra output port beat_cnt, out, 4*16, per-output 16-bit count of drained beats (slice i counts drain(i)).
  - Counters saturate at 16'hFFFF; they do not wrap.
  - Counters reset to 0 on rst_n.
- Without the macro: the port and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package demux_pkg:
  - SEL_W=2 and NOUT=4 localparams.
  - typedef sel_t (logic [SEL_W-1:0]).
  - CNT_W=16 and CNT_MAX constant.
- Sub-module demux_slot (one per output, generated ×4):
  - one-entry register with load/drain and the EMPTY/FULL FSM.
  - exposes valid, data, and can_accept = !valid | ready.
- The top level holds only the select decode, in_ready muxing and the optional counters.

Test Plan:
- Reset: drive rst_n=0 mid-stream with slot 2 FULL (data 8'hA5) -> out_valid=0000 immediately (asynchronous), out_data=0. After release, first beat sel=1 data 8'h11 -> out_valid=0010, out_data[15:8]=8'h11 one cycle later.
- Round robin: beats 8'h10..8'h13 with sel 0,1,2,3 on consecutive cycles, all out_ready=1 -> each appears on its output one cycle after acceptance; in_ready stays 1 for the whole sequence.
- Isolated stall: out_ready=1101, send sel=1 8'hB0, then sel=1 8'hB1 -> B0 held on output 1, in_ready=0 for B1. Then sel=3 8'hC3, presented next -> accepted and delivered despite the stall. Raise out_ready[1] -> B0 drains and B1 is accepted in the same cycle.
- Full-throughput drain+load: out_ready[0]=1, 10 back-to-back sel=0 beats 8'h00..8'h09 -> 10 beats out on 10 consecutive cycles, in order, with no bubbles.
- Protocol check: hold in_valid=1 with in_ready=0, change in_sel from 2 to 0 -> assertion fires. Stability of out_valid/out_data under out_ready=0 is checked by assertion throughout.
- With DEMUX1TO4_STREAM_CNT_EN: preload the output-3 counter path with 65537 drains on output 3 -> beat_cnt[63:48]=16'hFFFF (saturated); other slices equal their exact drain counts.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int SEL_W = 2;
  localparam int NOUT  = 4;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with the EMPTY/FULL slot FSM.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             can_accept_o
);

  slot_state_t      state_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: if (load_i) state_q <= SLOT_FULL;
        SLOT_FULL:  if (ready_i && !load_i) state_q <= SLOT_EMPTY;
        default:    state_q <= SLOT_EMPTY;
      endcase
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o      = (state_q == SLOT_FULL);
  assign data_o       = data_q;
  // A full slot can still take a beat in the cycle it drains.
  assign can_accept_o = !valid_o || ready_i;

`ifndef SYNTHESIS
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer with per-output holding slots.
// Optional drained-beat counters are enabled with DEMUX1TO4_STREAM_CNT_EN.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic [NOUT*WIDTH-1:0] out_data
`ifdef DEMUX1TO4_STREAM_CNT_EN
  ,
  output logic [NOUT*CNT_W-1:0] beat_cnt
`endif
);

  logic [NOUT-1:0] can_accept;
  logic [NOUT-1:0] load;
  sel_t            sel;

  assign sel = in_sel;
  // Depends only on the selected slot, never on in_valid.
  assign in_ready = can_accept[sel];

  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    assign load[i] = in_valid && in_ready && (sel == sel_t'(i));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load[i]),
      .data_i      (in_data),
      .ready_i     (out_ready[i]),
      .valid_o     (out_valid[i]),
      .data_o      (out_data[i*WIDTH +: WIDTH]),
      .can_accept_o(can_accept[i])
    );
  end

`ifdef DEMUX1TO4_STREAM_CNT_EN
  logic [NOUT-1:0]            drain;
  logic [NOUT-1:0][CNT_W-1:0] cnt_q;
  logic [NOUT-1:0][CNT_W-1:0] cnt_d;

  assign drain = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NOUT; i++) begin
      if (drain[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`else
  // Without counters the drain handshake is consumed entirely by the slots.
`endif

`ifndef SYNTHESIS
  a_producer_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(in_data) && $stable(in_sel))));
`endif

endmodule
